div_seq_ctrl: RTL and testbench

Sequencer for the EXE-stage divide path. It accepts one div/divu request from the EXE stage and drives the dividend/divisor AXI-stream channels of the divider IP. It waits for the IP result, then registers the quotient and remainder. A flush or exception cancel is absorbed without breaking the AXI-stream protocol, and results of cancelled operations are drained and discarded so the IP never holds a stale result.

---
 rtl/div_seq_ctrl_if.sv | 19 +
 rtl/div_seq_ctrl.sv | 87 ++++++++
 tb/tb_div_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: dividend/divisor AXI-stream channels and result channel between sequencer and divider IP.
interface div_seq_ctrl_if #(parameter int DATA_W = 32);
    logic                  s_dividend_tvalid;
    logic                  s_dividend_tready;
    logic [DATA_W-1:0]     s_dividend_tdata;
    logic                  s_divisor_tvalid;
    logic                  s_divisor_tready;
    logic [DATA_W-1:0]     s_divisor_tdata;
    logic                  m_dout_tvalid;
    logic [2*DATA_W-1:0]   m_dout_tdata;
    modport master (
        output s_dividend_tvalid, s_dividend_tdata, s_divisor_tvalid, s_divisor_tdata,
        input  s_dividend_tready, s_divisor_tready, m_dout_tvalid, m_dout_tdata
    );
    modport slave (
        input  s_dividend_tvalid, s_dividend_tdata, s_divisor_tvalid, s_divisor_tdata,
        output s_dividend_tready, s_divisor_tready, m_dout_tvalid, m_dout_tdata
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: issues one div/divu to the divider IP over AXI-stream and registers its result.
// Define DIV_ZERO_BYPASS_EN to answer divide-by-zero locally without using the IP.
module div_seq_ctrl #(
    parameter int DATA_W      = 32,
    parameter bit RES_QUOT_HI = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_signed,
    div_seq_ctrl_if.master    axis
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;
    state_t state, state_n;
    logic dvd_v, dvs_v, dvd_v_n, dvs_v_n, cancel_pend;
    logic [DATA_W-1:0] dvd_d, dvs_d, res_hi, res_lo;
    logic launch, bypass, capture;
`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = divisor == '0;
`else
    assign bypass = 1'b0;
`endif
    assign launch  = state == IDLE && start && !cancel;
    assign capture = state == WAIT && axis.m_dout_tvalid && !cancel;
    assign res_hi  = axis.m_dout_tdata[2*DATA_W-1:DATA_W];
    assign res_lo  = axis.m_dout_tdata[DATA_W-1:0];
    // A channel's valid only falls on its own handshake, so cancel cannot break the stream protocol.
    assign dvd_v_n = dvd_v && !axis.s_dividend_tready;
    assign dvs_v_n = dvs_v && !axis.s_divisor_tready;
    assign busy    = state != IDLE;
    assign done    = state == DONE && !cancel;
    assign axis.s_dividend_tvalid = dvd_v;
    assign axis.s_divisor_tvalid  = dvs_v;
    assign axis.s_dividend_tdata  = dvd_d;
    assign axis.s_divisor_tdata   = dvs_d;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (launch) state_n = bypass ? DONE : SEND;
            SEND:    if (!dvd_v_n && !dvs_v_n) state_n = (cancel_pend || cancel) ? DRAIN : WAIT;
            WAIT:    if (axis.m_dout_tvalid) state_n = cancel ? IDLE : DONE;
                     else if (cancel) state_n = DRAIN;
            DONE:    state_n = IDLE;
            DRAIN:   if (axis.m_dout_tvalid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvd_v       <= 1'b0;
            dvs_v       <= 1'b0;
            dvd_d       <= '0;
            dvs_d       <= '0;
            div_signed  <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            cancel_pend <= 1'b0;
        end else begin
            dvd_v       <= launch ? !bypass : dvd_v_n;
            dvs_v       <= launch ? !bypass : dvs_v_n;
            cancel_pend <= state_n == IDLE ? 1'b0 : cancel_pend || (state == SEND && cancel);
            if (launch) begin
                dvd_d      <= dividend;
                dvs_d      <= divisor;
                div_signed <= is_signed;
            end
            if (launch && bypass) begin
                quotient  <= '1;
                remainder <= dividend;
            end else if (capture) begin
                quotient  <= RES_QUOT_HI ? res_hi : res_lo;
                remainder <= RES_QUOT_HI ? res_lo : res_hi;
            end
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed checks of the divide sequencer with a hand-driven divider IP.
module tb_div_seq_ctrl;
    logic clk, resetn, start, is_signed, cancel, busy, done, div_signed;
    logic [31:0] dividend, divisor, quotient, remainder;
    int n_chk = 0, n_fail = 0, done_cnt = 0;
    div_seq_ctrl_if #(.DATA_W(32)) bus ();
    div_seq_ctrl #(.DATA_W(32), .RES_QUOT_HI(1'b1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .cancel(cancel), .busy(busy),
        .done(done), .quotient(quotient), .remainder(remainder),
        .div_signed(div_signed), .axis(bus.master)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        tick();
        start = 1'b0;
    endtask
    task automatic ip_result(input int lat, input logic [63:0] d);
        repeat (lat - 1) tick();
        bus.m_dout_tvalid = 1'b1; bus.m_dout_tdata = d;
        tick();
        bus.m_dout_tvalid = 1'b0;
    endtask
    task automatic test_reset;
        #12;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end n_chk++;
        if ({bus.s_dividend_tvalid, bus.s_divisor_tvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_tvalid got %b exp 00", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}); end n_chk++;
        if ({quotient, remainder} !== 64'd0) begin n_fail++; $display("FAIL rst_result got %h exp 0", {quotient, remainder}); end n_chk++;
        if (div_signed !== 1'b0) begin n_fail++; $display("FAIL rst_div_signed got %b exp 0", div_signed); end n_chk++;
        @(posedge clk); #1 resetn = 1'b1;
    endtask
    task automatic test_divu;
        done_cnt = 0;
        issue(1'b0, 32'd100, 32'd7);
        if ({bus.s_dividend_tvalid, bus.s_divisor_tvalid} !== 2'b11) begin n_fail++; $display("FAIL divu_tvalid got %b exp 11", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}); end n_chk++;
        if ({bus.s_dividend_tdata, bus.s_divisor_tdata} !== {32'd100, 32'd7}) begin n_fail++; $display("FAIL divu_tdata got %h exp %h", {bus.s_dividend_tdata, bus.s_divisor_tdata}, {32'd100, 32'd7}); end n_chk++;
        tick();
        if ({bus.s_dividend_tvalid, bus.s_divisor_tvalid} !== 2'b00) begin n_fail++; $display("FAIL divu_tvalid_drop got %b exp 00", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}); end n_chk++;
        ip_result(4, {32'd14, 32'd2});
        if (done !== 1'b1) begin n_fail++; $display("FAIL divu_done got %b exp 1", done); end n_chk++;
        if ({quotient, remainder} !== {32'd14, 32'd2}) begin n_fail++; $display("FAIL divu_result got %h exp %h", {quotient, remainder}, {32'd14, 32'd2}); end n_chk++;
        tick();
        if (busy !== 1'b0) begin n_fail++; $display("FAIL divu_idle got %b exp 0", busy); end n_chk++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL divu_done_cnt got %0d exp 1", done_cnt); end n_chk++;
    endtask
    task automatic test_div_signed;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        if (div_signed !== 1'b1) begin n_fail++; $display("FAIL sdiv_div_signed got %b exp 1", div_signed); end n_chk++;
        tick();
        ip_result(1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        if ({quotient, remainder} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL sdiv_result got %h exp %h", {quotient, remainder}, {32'hFFFF_FFFD, 32'hFFFF_FFFF}); end n_chk++;
        tick();
    endtask
    task automatic test_skewed_ready;
        done_cnt = 0;
        bus.s_dividend_tready = 1'b0; bus.s_divisor_tready = 1'b0;
        issue(1'b0, 32'd1000, 32'd10);
        bus.s_dividend_tready = 1'b1;
        tick();
        bus.s_dividend_tready = 1'b0;
        if ({bus.s_dividend_tvalid, bus.s_divisor_tvalid} !== 2'b01) begin n_fail++; $display("FAIL skew_t2 got %b exp 01", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}); end n_chk++;
        tick();
        if (bus.s_divisor_tvalid !== 1'b1) begin n_fail++; $display("FAIL skew_t3 got %b exp 1", bus.s_divisor_tvalid); end n_chk++;
        tick();
        if (bus.s_divisor_tvalid !== 1'b1) begin n_fail++; $display("FAIL skew_t4 got %b exp 1", bus.s_divisor_tvalid); end n_chk++;
        bus.s_divisor_tready = 1'b1;
        tick();
        if (bus.s_divisor_tvalid !== 1'b0) begin n_fail++; $display("FAIL skew_t5 got %b exp 0", bus.s_divisor_tvalid); end n_chk++;
        bus.s_dividend_tready = 1'b1;
        ip_result(2, {32'd100, 32'd0});
        if ({quotient, remainder} !== {32'd100, 32'd0}) begin n_fail++; $display("FAIL skew_result got %h exp %h", {quotient, remainder}, {32'd100, 32'd0}); end n_chk++;
        tick();
        if (done_cnt !== 1) begin n_fail++; $display("FAIL skew_done_cnt got %0d exp 1", done_cnt); end n_chk++;
    endtask
    task automatic test_cancel_wait;
        done_cnt = 0;
        issue(1'b0, 32'd50, 32'd5);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL cwait_drain_busy got %b exp 1", busy); end n_chk++;
        ip_result(3, {32'd10, 32'd0});
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cwait_idle got %b exp 0", busy); end n_chk++;
        if ({quotient, remainder} !== {32'd100, 32'd0}) begin n_fail++; $display("FAIL cwait_hold got %h exp %h", {quotient, remainder}, {32'd100, 32'd0}); end n_chk++;
        if (done_cnt !== 0) begin n_fail++; $display("FAIL cwait_done_cnt got %0d exp 0", done_cnt); end n_chk++;
        issue(1'b0, 32'd9, 32'd3);
        tick();
        ip_result(2, {32'd3, 32'd0});
        if ({quotient, remainder} !== {32'd3, 32'd0}) begin n_fail++; $display("FAIL cwait_next got %h exp %h", {quotient, remainder}, {32'd3, 32'd0}); end n_chk++;
        tick();
    endtask
    task automatic test_cancel_send;
        done_cnt = 0;
        bus.s_divisor_tready = 1'b0;
        issue(1'b0, 32'd77, 32'd7);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        if ({bus.s_dividend_tvalid, bus.s_divisor_tvalid} !== 2'b01) begin n_fail++; $display("FAIL csend_hold got %b exp 01", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}); end n_chk++;
        tick();
        if (bus.s_divisor_tvalid !== 1'b1) begin n_fail++; $display("FAIL csend_hold2 got %b exp 1", bus.s_divisor_tvalid); end n_chk++;
        bus.s_divisor_tready = 1'b1;
        tick();
        if ({busy, bus.s_divisor_tvalid} !== 2'b10) begin n_fail++; $display("FAIL csend_drain got %b exp 10", {busy, bus.s_divisor_tvalid}); end n_chk++;
        ip_result(2, {32'd11, 32'd0});
        if (busy !== 1'b0) begin n_fail++; $display("FAIL csend_idle got %b exp 0", busy); end n_chk++;
        if ({quotient, remainder, done_cnt[1:0]} !== {32'd3, 32'd0, 2'd0}) begin n_fail++; $display("FAIL csend_discard got %h/%h/%0d exp 3/0/0", quotient, remainder, done_cnt); end n_chk++;
    endtask
    task automatic test_cancel_done;
        done_cnt = 0;
        issue(1'b0, 32'd20, 32'd4);
        tick();
        ip_result(1, {32'd5, 32'd0});
        cancel = 1'b1;
        #1;
        if (done !== 1'b0) begin n_fail++; $display("FAIL cdone_suppress got %b exp 0", done); end n_chk++;
        if ({quotient, remainder} !== {32'd5, 32'd0}) begin n_fail++; $display("FAIL cdone_regs got %h exp %h", {quotient, remainder}, {32'd5, 32'd0}); end n_chk++;
        tick();
        cancel = 1'b0;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cdone_idle got %b exp 0", busy); end n_chk++;
        issue(1'b0, 32'd30, 32'd6);
        tick();
        bus.m_dout_tvalid = 1'b1; bus.m_dout_tdata = {32'd99, 32'd99}; cancel = 1'b1;
        tick();
        bus.m_dout_tvalid = 1'b0; cancel = 1'b0;
        if ({busy, quotient} !== {1'b0, 32'd5} || done_cnt !== 0) begin n_fail++; $display("FAIL cwait_hit got busy=%b q=%h done_cnt=%0d exp 0/5/0", busy, quotient, done_cnt); end n_chk++;
    endtask
    task automatic test_idle_ignore;
        bus.m_dout_tvalid = 1'b1; bus.m_dout_tdata = {32'hAAAA_AAAA, 32'h5555_5555};
        tick();
        bus.m_dout_tvalid = 1'b0;
        if ({busy, quotient} !== {1'b0, 32'd5}) begin n_fail++; $display("FAIL idle_mvalid got %b/%h exp 0/5", busy, quotient); end n_chk++;
        start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        if ({busy, bus.s_dividend_tvalid} !== 2'b00) begin n_fail++; $display("FAIL idle_start_cancel got %b exp 00", {busy, bus.s_dividend_tvalid}); end n_chk++;
    endtask
    task automatic test_div_zero;
        done_cnt = 0;
`ifdef DIV_ZERO_BYPASS_EN
        issue(1'b0, 32'h1234, 32'd0);
        if ({bus.s_dividend_tvalid, bus.s_divisor_tvalid, done} !== 3'b001) begin n_fail++; $display("FAIL dz_bypass got %b exp 001", {bus.s_dividend_tvalid, bus.s_divisor_tvalid, done}); end n_chk++;
        if ({quotient, remainder} !== {32'hFFFF_FFFF, 32'h1234}) begin n_fail++; $display("FAIL dz_result got %h exp %h", {quotient, remainder}, {32'hFFFF_FFFF, 32'h1234}); end n_chk++;
        tick();
`else
        issue(1'b0, 32'h1234, 32'd0);
        if ({bus.s_dividend_tvalid, bus.s_divisor_tvalid, done} !== 3'b110) begin n_fail++; $display("FAIL dz_issue got %b exp 110", {bus.s_dividend_tvalid, bus.s_divisor_tvalid, done}); end n_chk++;
        tick();
        ip_result(2, {32'hFFFF_FFFF, 32'h1234});
        if ({quotient, remainder} !== {32'hFFFF_FFFF, 32'h1234}) begin n_fail++; $display("FAIL dz_result got %h exp %h", {quotient, remainder}, {32'hFFFF_FFFF, 32'h1234}); end n_chk++;
        tick();
`endif
        if ({busy, done_cnt[1:0]} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL dz_done_cnt got busy=%b cnt=%0d exp 0/1", busy, done_cnt); end n_chk++;
    endtask
    task automatic test_reset_mid;
        bus.s_divisor_tready = 1'b0;
        issue(1'b1, 32'd9, 32'd3);
        #2 resetn = 1'b0;
        #1;
        if ({busy, bus.s_dividend_tvalid, bus.s_divisor_tvalid, div_signed} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ctrl got %b exp 0000", {busy, bus.s_dividend_tvalid, bus.s_divisor_tvalid, div_signed}); end n_chk++;
        if ({quotient, remainder} !== 64'd0) begin n_fail++; $display("FAIL rstmid_result got %h exp 0", {quotient, remainder}); end n_chk++;
        tick();
        resetn = 1'b1;
        bus.s_divisor_tready = 1'b1;
    endtask
    initial begin
        resetn = 1'b0; start = 1'b0; is_signed = 1'b0; cancel = 1'b0;
        dividend = '0; divisor = '0;
        bus.s_dividend_tready = 1'b1; bus.s_divisor_tready = 1'b1;
        bus.m_dout_tvalid = 1'b0; bus.m_dout_tdata = '0;
        test_reset();
        tick();
        test_divu();
        test_div_signed();
        test_skewed_ready();
        test_cancel_wait();
        test_cancel_send();
        test_cancel_done();
        test_idle_ignore();
        test_div_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
